// File: rtl/axi_crossbar_wr_steer.sv
// Routes slave W beats of one burst to the master port chosen by the write command;
// decode-error bursts are drained here and answered with a locally generated DECERR B response.
module axi_crossbar_wr_steer #(
  parameter int M_COUNT     = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int STRB_WIDTH  = DATA_WIDTH / 8,
  parameter int ID_WIDTH    = 8,
  parameter int WUSER_WIDTH = 1,
  localparam int CL_M_COUNT = (M_COUNT > 1) ? $clog2(M_COUNT) : 1
) (
  input  logic                   clk,
  input  logic                   rst,

  input  logic [CL_M_COUNT-1:0]  s_wc_select,
  input  logic                   s_wc_decerr,
  input  logic [ID_WIDTH-1:0]    s_wc_id,
  input  logic                   s_wc_valid,
  output logic                   s_wc_ready,

  input  logic [DATA_WIDTH-1:0]  s_axi_wdata,
  input  logic [STRB_WIDTH-1:0]  s_axi_wstrb,
  input  logic                   s_axi_wlast,
  input  logic [WUSER_WIDTH-1:0] s_axi_wuser,
  input  logic                   s_axi_wvalid,
  output logic                   s_axi_wready,

  output logic [DATA_WIDTH-1:0]  m_axi_wdata,
  output logic [STRB_WIDTH-1:0]  m_axi_wstrb,
  output logic                   m_axi_wlast,
  output logic [WUSER_WIDTH-1:0] m_axi_wuser,
  output logic [M_COUNT-1:0]     m_axi_wvalid,
  input  logic [M_COUNT-1:0]     m_axi_wready,

  output logic [ID_WIDTH-1:0]    m_decerr_bid,
  output logic [1:0]             m_decerr_bresp,
  output logic                   m_decerr_bvalid,
  input  logic                   m_decerr_bready,

  output logic                   overrun_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [CL_M_COUNT:0] M_COUNT_L = (CL_M_COUNT+1)'(M_COUNT);
  localparam logic [8:0]          BEAT_MAX  = 9'd256;

  state_t                state_q, state_d;
  logic [CL_M_COUNT-1:0] sel_q;
  logic [ID_WIDTH-1:0]   id_q;
  logic [8:0]            beat_cnt;
  logic                  sel_ok;
  logic                  cmd_fire;
  logic                  beat_fire;

  // An unreachable select stalls the burst rather than aliasing onto a real port.
  assign sel_ok = ({1'b0, sel_q} < M_COUNT_L);

  assign m_axi_wdata    = s_axi_wdata;
  assign m_axi_wstrb    = s_axi_wstrb;
  assign m_axi_wlast    = s_axi_wlast;
  assign m_axi_wuser    = s_axi_wuser;
  assign m_decerr_bid   = id_q;
  assign m_decerr_bresp = 2'b11;

  assign cmd_fire  = s_wc_valid && s_wc_ready;
  assign beat_fire = s_axi_wvalid && s_axi_wready;

  always_comb begin
    state_d         = state_q;
    s_wc_ready      = 1'b0;
    s_axi_wready    = 1'b0;
    m_axi_wvalid    = '0;
    m_decerr_bvalid = 1'b0;
    case (state_q)
      IDLE: begin
        s_wc_ready = !rst;
        if (s_wc_valid && !rst) begin
          state_d = s_wc_decerr ? DRAIN : DATA;
        end
      end
      DATA: begin
        if (sel_ok) begin
          m_axi_wvalid[sel_q] = s_axi_wvalid;
          s_axi_wready        = m_axi_wready[sel_q];
        end
        if (beat_fire && s_axi_wlast) begin
          state_d = IDLE;
        end
      end
      DRAIN: begin
        s_axi_wready = 1'b1;
        if (beat_fire && s_axi_wlast) begin
          state_d = RESP;
        end
      end
      RESP: begin
        m_decerr_bvalid = 1'b1;
        if (m_decerr_bready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      id_q        <= '0;
      beat_cnt    <= '0;
      overrun_err <= 1'b0;
    end else begin
      state_q <= state_d;
      if (cmd_fire) begin
        sel_q    <= s_wc_select;
        id_q     <= s_wc_id;
        beat_cnt <= '0;
      end else if (beat_fire) begin
        if (beat_cnt != BEAT_MAX) begin
          beat_cnt <= beat_cnt + 9'd1;
        end
        // The 256th beat without WLAST means the burst exceeded the AXI4 maximum.
        if (!s_axi_wlast && (beat_cnt >= BEAT_MAX - 9'd1)) begin
          overrun_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_crossbar_wr_steer.sv
// Directed bench for axi_crossbar_wr_steer: routing, decode-error drain/response,
// back-to-back bursts, overrun flag and mid-burst reset.
module tb_axi_crossbar_wr_steer;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  s_wc_select;
  logic        s_wc_decerr;
  logic [7:0]  s_wc_id;
  logic        s_wc_valid;
  logic        s_wc_ready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wlast;
  logic [0:0]  s_axi_wuser;
  logic        s_axi_wvalid;
  logic        s_axi_wready;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wlast;
  logic [0:0]  m_axi_wuser;
  logic [3:0]  m_axi_wvalid;
  logic [3:0]  m_axi_wready;
  logic [7:0]  m_decerr_bid;
  logic [1:0]  m_decerr_bresp;
  logic        m_decerr_bvalid;
  logic        m_decerr_bready;
  logic        overrun_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi_crossbar_wr_steer dut (
    .clk             (clk),
    .rst             (rst),
    .s_wc_select     (s_wc_select),
    .s_wc_decerr     (s_wc_decerr),
    .s_wc_id         (s_wc_id),
    .s_wc_valid      (s_wc_valid),
    .s_wc_ready      (s_wc_ready),
    .s_axi_wdata     (s_axi_wdata),
    .s_axi_wstrb     (s_axi_wstrb),
    .s_axi_wlast     (s_axi_wlast),
    .s_axi_wuser     (s_axi_wuser),
    .s_axi_wvalid    (s_axi_wvalid),
    .s_axi_wready    (s_axi_wready),
    .m_axi_wdata     (m_axi_wdata),
    .m_axi_wstrb     (m_axi_wstrb),
    .m_axi_wlast     (m_axi_wlast),
    .m_axi_wuser     (m_axi_wuser),
    .m_axi_wvalid    (m_axi_wvalid),
    .m_axi_wready    (m_axi_wready),
    .m_decerr_bid    (m_decerr_bid),
    .m_decerr_bresp  (m_decerr_bresp),
    .m_decerr_bvalid (m_decerr_bvalid),
    .m_decerr_bready (m_decerr_bready),
    .overrun_err     (overrun_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int         k;
    logic [4:0] rdy_pat;
    logic [1:0] sels [3];

    rst = 1'b1;
    s_wc_valid = 1'b1; s_wc_select = 2'd2; s_wc_decerr = 1'b0; s_wc_id = 8'h11;
    s_axi_wdata = 32'h0; s_axi_wstrb = 4'hF; s_axi_wlast = 1'b0; s_axi_wuser = 1'b0;
    s_axi_wvalid = 1'b1; m_axi_wready = 4'hF; m_decerr_bready = 1'b0;
    tick();
    tick();
    #1;
    chk("rst_wc_ready", s_wc_ready, 0);
    chk("rst_wready", s_axi_wready, 0);
    chk("rst_m_wvalid", m_axi_wvalid, 0);
    chk("rst_bvalid", m_decerr_bvalid, 0);
    chk("rst_overrun", overrun_err, 0);

    // first cycle after reset: command accepted, no W beat taken
    rst = 1'b0;
    #1;
    chk("accept_wc_ready", s_wc_ready, 1);
    chk("accept_no_beat", s_axi_wready, 0);
    chk("accept_m_wvalid", m_axi_wvalid, 0);
    tick();
    s_wc_valid = 1'b0;

    // 4-beat burst to port 2, port-2 ready pattern 1,0,1,1,1
    rdy_pat = 5'b11101;
    k = 0;
    for (int c = 0; c < 5; c++) begin
      s_axi_wdata  = 32'hA000_0000 + k;
      s_axi_wlast  = (k == 3);
      s_axi_wvalid = 1'b1;
      m_axi_wready = {1'b1, rdy_pat[c], 2'b11};
      #1;
      chk("b4_m_wvalid", m_axi_wvalid, 4'b0100);
      chk("b4_wready", s_axi_wready, rdy_pat[c]);
      chk("b4_wc_ready", s_wc_ready, 0);
      chk("b4_wdata", m_axi_wdata, 32'hA000_0000 + k);
      chk("b4_wlast", m_axi_wlast, (k == 3));
      if (s_axi_wvalid && s_axi_wready) k++;
      tick();
    end
    s_axi_wvalid = 1'b0;
    #1;
    chk("b4_beat_count", k, 4);
    chk("b4_wc_ready_back", s_wc_ready, 1);
    chk("b4_idle_m_wvalid", m_axi_wvalid, 0);

    // decode-error burst id 0x5A, 3 beats, masters not ready
    s_wc_valid = 1'b1; s_wc_decerr = 1'b1; s_wc_id = 8'h5A;
    tick();
    s_wc_valid = 1'b0; s_wc_decerr = 1'b0;
    m_axi_wready = 4'h0;
    for (int b = 0; b < 3; b++) begin
      s_axi_wvalid = 1'b1;
      s_axi_wlast  = (b == 2);
      #1;
      chk("de_wready", s_axi_wready, 1);
      chk("de_m_wvalid", m_axi_wvalid, 0);
      chk("de_bvalid_early", m_decerr_bvalid, 0);
      tick();
    end
    s_axi_wvalid = 1'b0;
    s_wc_valid = 1'b1; s_wc_select = 2'd0;
    #1;
    chk("de_bvalid", m_decerr_bvalid, 1);
    chk("de_bid", m_decerr_bid, 8'h5A);
    chk("de_bresp", m_decerr_bresp, 2'b11);
    for (int h = 0; h < 5; h++) begin
      chk("de_bvalid_hold", m_decerr_bvalid, 1);
      chk("de_cmd_blocked", s_wc_ready, 0);
      tick();
    end
    m_decerr_bready = 1'b1;
    #1;
    chk("de_bvalid_at_rdy", m_decerr_bvalid, 1);
    tick();
    m_decerr_bready = 1'b0;

    // back-to-back single-beat bursts to ports 0, 1, 3
    m_axi_wready = 4'hF;
    sels[0] = 2'd0; sels[1] = 2'd1; sels[2] = 2'd3;
    for (int i = 0; i < 3; i++) begin
      s_wc_select  = sels[i];
      s_wc_valid   = 1'b1;
      s_axi_wvalid = 1'b1;
      s_axi_wlast  = 1'b1;
      s_axi_wdata  = 32'hB000_0000 + i;
      #1;
      chk("bb_bvalid_clear", m_decerr_bvalid, 0);
      chk("bb_wc_ready", s_wc_ready, 1);
      chk("bb_no_beat", s_axi_wready, 0);
      tick();
      if (i == 2) s_wc_valid = 1'b0;
      #1;
      chk("bb_m_wvalid", m_axi_wvalid, 4'b0001 << sels[i]);
      chk("bb_wready", s_axi_wready, 1);
      chk("bb_wc_ready_busy", s_wc_ready, 0);
      chk("bb_wdata", m_axi_wdata, 32'hB000_0000 + i);
      tick();
    end
    s_axi_wvalid = 1'b0;

    // 257-beat burst to port 3, WLAST only on beat 257
    s_wc_valid = 1'b1; s_wc_select = 2'd3;
    #1;
    tick();
    s_wc_valid = 1'b0;
    for (int b = 0; b < 257; b++) begin
      s_axi_wvalid = 1'b1;
      s_axi_wlast  = (b == 256);
      s_axi_wdata  = b;
      #1;
      chk("ov_flag", overrun_err, (b >= 256));
      chk("ov_m_wvalid", m_axi_wvalid, 4'b1000);
      tick();
    end
    s_axi_wvalid = 1'b0;
    #1;
    chk("ov_sticky", overrun_err, 1);
    chk("ov_end_idle", s_wc_ready, 1);

    // decode-error burst interrupted by reset after 2 beats
    s_wc_valid = 1'b1; s_wc_decerr = 1'b1; s_wc_id = 8'h33;
    tick();
    s_wc_valid = 1'b0; s_wc_decerr = 1'b0;
    for (int b = 0; b < 2; b++) begin
      s_axi_wvalid = 1'b1;
      s_axi_wlast  = 1'b0;
      #1;
      chk("rd_wready", s_axi_wready, 1);
      chk("rd_overrun_kept", overrun_err, 1);
      tick();
    end
    rst = 1'b1;
    #1;
    chk("rd_wc_ready_in_rst", s_wc_ready, 0);
    tick();
    #1;
    chk("rd_wready", s_axi_wready, 0);
    chk("rd_bvalid", m_decerr_bvalid, 0);
    chk("rd_overrun_clr", overrun_err, 0);
    chk("rd_m_wvalid", m_axi_wvalid, 0);
    rst = 1'b0;
    s_axi_wvalid = 1'b0;
    #1;
    chk("rd_idle_wc_ready", s_wc_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_crossbar_wr_steer.md
Name: axi_crossbar_wr_steer

Overview:
Write-data steering stage that sits directly downstream of the crossbar address-decode block's write-command output. It accepts one write command per burst, carrying the target select, decode-error flag and AWID. It then routes the slave-side W beats to the selected master port until WLAST. For decode-error bursts it sinks the W beats and issues a DECERR B response itself, so unmapped writes never reach a master.

Parameters:
M_COUNT, 4, number of master-side W ports
DATA_WIDTH, 32, W data width in bits
STRB_WIDTH, DATA_WIDTH/8, W strobe width
ID_WIDTH, 8, AWID/BID width
WUSER_WIDTH, 1, W user width, passed through unmodified
CL_M_COUNT (local), max(1,$clog2(M_COUNT)), select width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
s_wc_select  in  CL_M_COUNT  target master index
s_wc_decerr  in  1  command is a decode error
s_wc_id  in  ID_WIDTH  AWID of the burst
s_wc_valid  in  1  command valid
s_wc_ready  out  1  command accepted
s_axi_wdata  in  DATA_WIDTH  slave W data
s_axi_wstrb  in  STRB_WIDTH  slave W strobe
s_axi_wlast  in  1  slave W last
s_axi_wuser  in  WUSER_WIDTH  slave W user
s_axi_wvalid  in  1  slave W valid
s_axi_wready  out  1  slave W ready
m_axi_wdata  out  DATA_WIDTH  shared master W data (= s_axi_wdata)
m_axi_wstrb  out  STRB_WIDTH  shared master W strobe
m_axi_wlast  out  1  shared master W last
m_axi_wuser  out  WUSER_WIDTH  shared master W user
m_axi_wvalid  out  M_COUNT  per-master W valid
m_axi_wready  in  M_COUNT  per-master W ready
m_decerr_bid  out  ID_WIDTH  DECERR response ID
m_decerr_bresp  out  2  always 2'b11
m_decerr_bvalid  out  1  DECERR response valid
m_decerr_bready  in  1  DECERR response ready
overrun_err  out  1  sticky: 256 beats seen without WLAST

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high. Every register clears on the rising edge of clk while rst=1.
- Reset values: state=IDLE, m_axi_wvalid=0, s_axi_wready=0, m_decerr_bvalid=0, beat_cnt=0, overrun_err=0. s_wc_ready is 0 while rst=1.
- State machine, IDLE: s_wc_ready=!rst, s_axi_wready=0. On s_wc_valid&&s_wc_ready, latch select and id, clear beat_cnt, then go to DRAIN if decerr, else DATA. W beats are never accepted in the command-accept cycle.
- State machine, DATA: zero-latency combinational pass-through.
  - m_axi_wvalid[sel]=s_axi_wvalid; all other bits are 0.
  - s_axi_wready=m_axi_wready[sel].
  - A beat completes when s_axi_wvalid&&s_axi_wready. A completing beat with wlast=1 returns to IDLE.
- State machine, DRAIN: s_axi_wready=1 and m_axi_wvalid=0. A completing beat with wlast=1 moves to RESP.
- State machine, RESP: m_decerr_bvalid=1, bid=latched id, bresp=2'b11. On bready, go to IDLE. Holds indefinitely under backpressure.
- Data outputs: m_axi_wdata/wstrb/wlast/wuser always mirror the s_axi inputs. Validity is qualified only by m_axi_wvalid.
- beat_cnt: 9-bit, increments on every completed beat in DATA or DRAIN.
  - When it reaches 256 with no WLAST yet, overrun_err sets and stays set until reset.
  - Routing continues and the burst still ends only on WLAST. The counter saturates at 256.
- Select out of range (sel >= M_COUNT): all m_axi_wvalid=0 and s_axi_wready=0, so the burst stalls. The upstream block never issues this.
- Reset mid-burst: the burst is abandoned, the state returns to IDLE, and any pending bvalid drops. W beats are not flushed.
- Throughput: one command per burst plus one bubble cycle per burst. Back-to-back single-beat bursts sustain one beat every 2 cycles.

Test Plan:
- Reset release with wc_valid=1, sel=2 -> s_wc_ready=0 during rst. Accepted the first cycle after; state DATA, no beat in the accept cycle.
- 4-beat burst to sel=2 with m_axi_wready[2] toggling 1,0,1,1,1 -> exactly 4 beats on port 2, data in order. m_axi_wvalid[0,1,3] stay 0 and s_wc_ready returns the cycle after the WLAST beat.
- Decerr command id=0x5A, 3-beat burst -> s_axi_wready=1 throughout and no m_axi_wvalid. bvalid rises the cycle after WLAST with bid=0x5A, bresp=2'b11; hold bready=0 for 5 cycles -> bvalid holds, next command blocked.
- Back-to-back single-beat bursts sel=0,1,3 -> each lands on the correct port; s_wc_ready alternates with beats, one beat every 2 cycles.
- 257-beat burst without WLAST until beat 257 -> overrun_err=1 after beat 256, stays 1 through later bursts until rst.
- rst asserted in DRAIN after 2 beats -> next cycle state IDLE, bvalid=0, s_axi_wready=0, overrun_err=0.
